// File: rtl/timer_sequencer.sv
// Queues timer requests and sequences them one at a time through a downstream countdown
// timer: arm it, wait for its expiry pulse, then hand an event to the consumer.
module timer_sequencer #(
  parameter int unsigned ISIZE = 16,
  parameter int unsigned IDW   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [ISIZE-1:0]         req_period_i,
  input  logic [IDW-1:0]           req_id_i,
  input  logic                     req_repeat_i,
  input  logic                     cancel_i,
  output logic [ISIZE-1:0]         cb_countdown_o,
  output logic                     cb_reset_o,
  input  logic                     cb_callback_i,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [IDW-1:0]           evt_id_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  typedef enum logic [1:0] {StIdle, StArm, StWait, StNotify} state_e;

  logic [ISIZE-1:0] per_mem [DEPTH];
  logic [IDW-1:0]   id_mem  [DEPTH];
  logic             rpt_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;

  state_e           state_q;
  logic             cb_reset_q;
  logic [ISIZE-1:0] cb_countdown_q;
  logic             evt_valid_q;
  logic [IDW-1:0]   evt_id_q;
  logic [IDW-1:0]   act_id_q;
  logic             act_rpt_q;
  logic             cb_prev_q;
  logic             cb_rise;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign push  = req_valid_i && !full;
  // The head is only consumed when the sequencer is idle, i.e. one timer active at a time.
  assign pop   = (state_q == StIdle) && !empty;
  assign cb_rise = cb_callback_i && !cb_prev_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      per_mem[wr_ptr_q] <= req_period_i;
      id_mem[wr_ptr_q]  <= req_id_i;
      rpt_mem[wr_ptr_q] <= req_repeat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      cb_reset_q     <= 1'b0;
      cb_countdown_q <= '0;
      evt_valid_q    <= 1'b0;
      evt_id_q       <= '0;
      act_id_q       <= '0;
      act_rpt_q      <= 1'b0;
      cb_prev_q      <= 1'b0;
    end else begin
      cb_prev_q <= cb_callback_i;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            // cb_countdown_q doubles as the active period, reused on periodic reload.
            cb_countdown_q <= per_mem[rd_ptr_q];
            act_id_q       <= id_mem[rd_ptr_q];
            act_rpt_q      <= rpt_mem[rd_ptr_q];
            cb_reset_q     <= 1'b1;
            state_q        <= StArm;
          end
        end
        StArm: begin
          cb_reset_q <= 1'b0;
          state_q    <= cancel_i ? StIdle : StWait;
        end
        StWait: begin
          if (cancel_i) begin
            state_q <= StIdle;
          end else if (cb_rise) begin
            evt_valid_q <= 1'b1;
            evt_id_q    <= act_id_q;
            state_q     <= StNotify;
          end
        end
        StNotify: begin
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            if (act_rpt_q && !cancel_i) begin
              cb_reset_q <= 1'b1;
              state_q    <= StArm;
            end else begin
              state_q <= StIdle;
            end
          end else if (cancel_i) begin
            evt_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o    = !full;
  assign fifo_count_o   = count_q;
  assign cb_reset_o     = cb_reset_q;
  assign cb_countdown_o = cb_countdown_q;
  assign evt_valid_o    = evt_valid_q;
  assign evt_id_o       = evt_id_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a queue-based reference model of the sequencer.
module tb_timer_sequencer;

  localparam int unsigned ISIZE = 16;
  localparam int unsigned IDW   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  localparam int PhIdle   = 0;
  localparam int PhArm    = 1;
  localparam int PhWait   = 2;
  localparam int PhNotify = 3;

  typedef struct packed {
    logic [ISIZE-1:0] period;
    logic [IDW-1:0]   id;
    logic             rpt;
  } req_t;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready_o;
  logic [ISIZE-1:0] req_period;
  logic [IDW-1:0]   req_id;
  logic             req_repeat;
  logic             cancel;
  logic [ISIZE-1:0] cb_countdown_o;
  logic             cb_reset_o;
  logic             cb_callback;
  logic             evt_valid_o;
  logic             evt_ready;
  logic [IDW-1:0]   evt_id_o;
  logic             busy_o;
  logic [CW-1:0]    fifo_count_o;

  timer_sequencer #(
    .ISIZE(ISIZE),
    .IDW  (IDW),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready_o),
    .req_period_i  (req_period),
    .req_id_i      (req_id),
    .req_repeat_i  (req_repeat),
    .cancel_i      (cancel),
    .cb_countdown_o(cb_countdown_o),
    .cb_reset_o    (cb_reset_o),
    .cb_callback_i (cb_callback),
    .evt_valid_o   (evt_valid_o),
    .evt_ready_i   (evt_ready),
    .evt_id_o      (evt_id_o),
    .busy_o        (busy_o),
    .fifo_count_o  (fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending requests, the request being timed, and which phase it is in.
  req_t mq[$];
  req_t act;
  int   ph;
  logic prev_cb;

  int               n_evt = 0;
  logic [IDW-1:0]   ev_ids[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    act     = '0;
    ph      = PhIdle;
    prev_cb = 1'b0;
  endfunction

  function automatic void model_step();
    bit   accept;
    req_t r;
    if (reset) begin
      model_reset();
      return;
    end
    accept = req_valid && (mq.size() < int'(DEPTH));
    case (ph)
      PhIdle:   if (mq.size() > 0) begin act = mq.pop_front(); ph = PhArm; end
      PhArm:    ph = cancel ? PhIdle : PhWait;
      PhWait: begin
        if (cancel) ph = PhIdle;
        else if (cb_callback && !prev_cb) ph = PhNotify;
      end
      PhNotify: begin
        if (evt_ready) ph = (act.rpt && !cancel) ? PhArm : PhIdle;
        else if (cancel) ph = PhIdle;
      end
      default: ph = PhIdle;
    endcase
    if (accept) begin
      r.period = req_period;
      r.id     = req_id;
      r.rpt    = req_repeat;
      mq.push_back(r);
    end
    prev_cb = cb_callback;
  endfunction

  task automatic compare();
    check("req_ready", req_ready_o, mq.size() < int'(DEPTH));
    check("fifo_count", fifo_count_o, mq.size());
    check("cb_reset", cb_reset_o, ph == PhArm);
    check("cb_countdown", cb_countdown_o, act.period);
    check("evt_valid", evt_valid_o, ph == PhNotify);
    if (ph == PhNotify) check("evt_id", evt_id_o, act.id);
    check("busy", busy_o, ph != PhIdle);
  endtask

  task automatic step();
    if (!reset && evt_valid_o && evt_ready) begin
      n_evt++;
      ev_ids.push_back(evt_id_o);
    end
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    req_valid   = 1'b0;
    req_period  = '0;
    req_id      = '0;
    req_repeat  = 1'b0;
    cancel      = 1'b0;
    cb_callback = 1'b0;
    evt_ready   = 1'b0;
  endtask

  task automatic push_req(input int period, input int id, input bit rpt);
    req_valid  = 1'b1;
    req_period = ISIZE'(period);
    req_id     = IDW'(id);
    req_repeat = rpt;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic wait_ph(input int p, input string tag);
    int k = 0;
    while (ph != p && k < 50) begin
      step();
      k++;
    end
    if (ph != p) check(tag, ph, p);
  endtask

  task automatic serve(input int max);
    int k = 0;
    evt_ready = 1'b1;
    while ((ph != PhIdle || mq.size() != 0) && k < max) begin
      cb_callback = (ph == PhWait) && !cb_callback;
      step();
      k++;
    end
    cb_callback = 1'b0;
    evt_ready   = 1'b0;
    if (k >= max) check("serve_timeout", k, 0);
  endtask

  initial begin
    int n0;
    int cb_left = 0;
    idle_inputs();
    model_reset();

    // Reset state
    reset = 1'b1;
    step();
    step();
    check("rst_evt_id", evt_id_o, 0);
    check("rst_countdown", cb_countdown_o, 0);
    reset = 1'b0;
    step();
    check("rst_ready", req_ready_o, 1);

    // Single one-shot request, 2-cycle callback pulse
    n0 = n_evt;
    push_req(5, 3, 0);
    step();
    check("lat_cb_reset", cb_reset_o, 1);
    check("lat_countdown", cb_countdown_o, 5);
    step();
    check("lat_one_cycle", cb_reset_o, 0);
    cb_callback = 1'b1;
    step();
    step();
    cb_callback = 1'b0;
    evt_ready   = 1'b1;
    step();
    step();
    evt_ready = 1'b0;
    step();
    check("s1_events", n_evt - n0, 1);
    check("s1_id", ev_ids[$], 3);

    // Fill the FIFO while the first request is active; overflow is ignored
    n0 = n_evt;
    ev_ids.delete();
    push_req(3, 0, 0);
    wait_ph(PhWait, "s2_reach_wait");
    for (int i = 1; i <= int'(DEPTH) + 1; i++) begin
      req_valid  = 1'b1;
      req_period = ISIZE'(3);
      req_id     = IDW'(i);
      step();
    end
    req_valid = 1'b0;
    check("s2_full_ready", req_ready_o, 0);
    check("s2_full_count", fifo_count_o, DEPTH);
    serve(300);
    check("s2_events", n_evt - n0, DEPTH + 1);
    for (int i = 0; i <= int'(DEPTH); i++) check("s2_order", ev_ids[i], i);

    // Periodic request: stalled event, reload, then cancel in WAIT
    n0 = n_evt;
    push_req(9, 7, 1);
    wait_ph(PhWait, "s3_reach_wait");
    cb_callback = 1'b1;
    step();
    cb_callback = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("s3_hold_valid", evt_valid_o, 1);
      check("s3_hold_id", evt_id_o, 7);
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("s3_rearm", cb_reset_o, 1);
    check("s3_period", cb_countdown_o, 9);
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("s3_cancel_idle", busy_o, 0);
    for (int i = 0; i < 3; i++) begin
      cb_callback = 1'b1;
      step();
      cb_callback = 1'b0;
      step();
    end
    check("s3_events", n_evt - n0, 1);

    // Cancel in NOTIFY: dropped without ready, delivered with ready
    n0 = n_evt;
    push_req(4, 2, 0);
    wait_ph(PhWait, "s4_reach_wait_a");
    cb_callback = 1'b1;
    step();
    cb_callback = 1'b0;
    cancel      = 1'b1;
    step();
    cancel = 1'b0;
    check("s4_dropped", evt_valid_o, 0);
    check("s4_drop_idle", busy_o, 0);
    push_req(4, 9, 1);
    wait_ph(PhWait, "s4_reach_wait_b");
    cb_callback = 1'b1;
    step();
    cb_callback = 1'b0;
    cancel      = 1'b1;
    evt_ready   = 1'b1;
    step();
    cancel    = 1'b0;
    evt_ready = 1'b0;
    check("s4_idle", busy_o, 0);
    check("s4_events", n_evt - n0, 1);
    check("s4_id", ev_ids[$], 9);

    // Reset mid-WAIT with queued requests, then a late callback
    n0 = n_evt;
    push_req(6, 1, 0);
    wait_ph(PhWait, "s5_reach_wait");
    push_req(6, 2, 0);
    push_req(6, 4, 0);
    check("s5_count", fifo_count_o, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("s5_rst_count", fifo_count_o, 0);
    check("s5_rst_busy", busy_o, 0);
    check("s5_rst_evt", evt_valid_o, 0);
    cb_callback = 1'b1;
    step();
    step();
    cb_callback = 1'b0;
    step();
    step();
    check("s5_events", n_evt - n0, 0);

    // Callback held high across ARM into WAIT
    n0 = n_evt;
    cb_callback = 1'b1;
    push_req(0, 5, 0);
    for (int i = 0; i < 5; i++) step();
    check("s6_no_evt", evt_valid_o, 0);
    cb_callback = 1'b0;
    step();
    cb_callback = 1'b1;
    step();
    check("s6_evt", evt_valid_o, 1);
    cb_callback = 1'b0;
    evt_ready   = 1'b1;
    step();
    evt_ready = 1'b0;
    check("s6_events", n_evt - n0, 1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      req_valid  = ($urandom_range(0, 3) == 0);
      req_period = ISIZE'($urandom_range(0, 5));
      req_id     = IDW'($urandom);
      req_repeat = ($urandom_range(0, 5) == 0);
      cancel     = ($urandom_range(0, 19) == 0);
      evt_ready  = ($urandom_range(0, 2) != 0);
      if (cb_left > 0) begin
        cb_callback = 1'b1;
        cb_left--;
      end else begin
        cb_callback = 1'b0;
        if ($urandom_range(0, 4) == 0) cb_left = $urandom_range(1, 2);
      end
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
